vga_fb_arbiter: RTL
===================

VGA_FB_ARBITER -- requirements
Module: vga_fb_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 17, framebuffer word address width.
REQ-002 The block SHALL have parameter DATA_W, default 8, pixel/word width.
REQ-003 The block SHALL have parameter FB_WORDS, default 76800, words per frame (320x240).
REQ-004 The block SHALL have parameter FIFO_DEPTH, default 16 (power of two), display prefetch depth.
REQ-005 The block SHALL have parameter LOW_WATER, default 4, FIFO occupancy below which display reads take priority.
REQ-006 The block SHALL have ports i_clk in 1 clock; i_rst in 1 reset, synchronous, active-high.
REQ-007 The block SHALL have ports i_frame_start in 1 one-cycle pulse at frame start; i_pix_pop in 1 display consumes one pixel.
REQ-008 The block SHALL have ports o_pix_data out DATA_W head pixel; o_underflow out 1 sticky underflow flag.
REQ-009 The block SHALL have ports i_wr_req in 1, i_wr_addr in ADDR_W, i_wr_data in DATA_W, o_wr_ack out 1 writer interface.
REQ-010 The block SHALL have ports o_mem_en out 1, o_mem_we out 1, o_mem_addr out ADDR_W, o_mem_wdata out DATA_W, i_mem_rdata in DATA_W single-port RAM, read latency 1.
REQ-011 The block SHALL have port o_uflow_cnt out 16 underflow event count.

Function
REQ-012 The FSM SHALL have states WAIT_FRAME (no display reads) and RUN; reset enters WAIT_FRAME; i_frame_start moves to RUN.
REQ-013 Per cycle at most one RAM access SHALL issue; level = FIFO occupancy + in-flight read (0/1).
REQ-014 In RUN with level < LOW_WATER, a display read SHALL be granted over a pending write.
REQ-015 Otherwise a pending i_wr_req SHALL be granted: o_mem_en=1, o_mem_we=1, addr/data from writer, o_wr_ack high that same cycle.
REQ-016 Otherwise in RUN with level < FIFO_DEPTH, a display read SHALL be issued.
REQ-017 A display read SHALL use rd_addr then increment it; rd_addr SHALL wrap from FB_WORDS-1 to 0.
REQ-018 Read data SHALL be pushed into the FIFO the cycle after issue; the FIFO SHALL never overflow.
REQ-019 o_pix_data SHALL show FIFO head combinationally; i_pix_pop with FIFO non-empty SHALL pop.
REQ-020 i_pix_pop with FIFO empty SHALL set o_underflow, leave the FIFO unchanged, and o_pix_data SHALL read 0.
REQ-021 i_frame_start SHALL flush the FIFO, set rd_addr to 0, discard in-flight read data, and clear o_underflow; a write granted that cycle SHALL still complete.
REQ-022 Push and pop in the same cycle SHALL keep occupancy unchanged.
REQ-023 In WAIT_FRAME writes SHALL be granted whenever requested.
REQ-024 o_mem_en SHALL be 0 in idle cycles.

Reset
REQ-025 On i_rst the block SHALL reset to: state WAIT_FRAME, FIFO empty, rd_addr 0, no in-flight read, o_underflow 0, o_wr_ack 0, o_mem_en 0, o_mem_we 0, o_uflow_cnt 0.
REQ-026 i_rst mid-read SHALL discard the returning data.

Configuration
REQ-027 With VGA_FB_ARB_UFLOW_CNT_EN defined, o_uflow_cnt SHALL increment (saturating at 16'hFFFF) per underflow pop, cleared only by i_rst.
REQ-028 Without VGA_FB_ARB_UFLOW_CNT_EN, o_uflow_cnt SHALL be constant 0 and no counter logic SHALL exist.

Verification
REQ-029 Reset, then i_frame_start, no pops -> 16 reads at addr 0..15, then o_mem_en stays 0; FIFO full.
REQ-030 FIFO at 2 with i_wr_req held -> read issued first, write acked once level >= 4.
REQ-031 Pop every cycle from empty FIFO in WAIT_FRAME -> o_underflow=1, o_pix_data=0; with macro o_uflow_cnt counts 1,2,3...
REQ-032 Pop FB_WORDS pixels with RAM preloaded -> data sequence matches RAM 0..FB_WORDS-1, then address wraps to 0.
REQ-033 i_frame_start while read in flight -> stale data not pushed; next read addr 0, o_underflow cleared.
REQ-034 i_wr_req at addr 0x00123 data 0xA5 in WAIT_FRAME -> o_mem_we=1, o_mem_addr=0x00123, o_wr_ack pulse same cycle.

Source files
------------

// File: rtl/vga_fb_arbiter.sv
// Single-port framebuffer arbiter: display prefetch FIFO vs. writer port. Grants are combinational, read data lands in the FIFO one cycle after issue.
// Writer stalls (no o_wr_ack) while the display is below its low-water mark. `VGA_FB_ARB_UFLOW_CNT_EN adds the saturating underflow counter.
module vga_fb_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     flush,
  input  logic                     push_vld,
  input  logic [DATA_W-1:0]        push_dat,
  input  logic                     pop_vld,
  output logic [DATA_W-1:0]        head_dat,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;

  always_ff @(posedge i_clk) begin
    if (i_rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_vld) wr_ptr <= wr_ptr + AW'(1);
      if (pop_vld)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_vld, pop_vld})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (push_vld) mem[wr_ptr] <= push_dat;
  end

  assign head_dat = mem[rd_ptr];
  assign empty    = (count == '0);
endmodule

module vga_fb_arbiter #(
  parameter int ADDR_W     = 17,
  parameter int DATA_W     = 8,
  parameter int FB_WORDS   = 76800,
  parameter int FIFO_DEPTH = 16,
  parameter int LOW_WATER  = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_frame_start,
  input  logic              i_pix_pop,
  output logic [DATA_W-1:0] o_pix_data,
  output logic              o_underflow,
  input  logic              i_wr_req,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  output logic              o_wr_ack,
  output logic              o_mem_en,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic [DATA_W-1:0] i_mem_rdata,
  output logic [15:0]       o_uflow_cnt
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW:0]       LW_LVL   = (CW+1)'(LOW_WATER);
  localparam logic [CW:0]       FULL_LVL = (CW+1)'(FIFO_DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ADR = ADDR_W'(FB_WORDS - 1);

  typedef enum logic {WAIT_FRAME, RUN} state_t;

  state_t            state;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_inflight;
  logic [CW-1:0]     fifo_cnt;
  logic              fifo_empty;
  logic [DATA_W-1:0] fifo_head;
  logic [CW:0]       level;
  logic              disp_active;
  logic              rd_grant;
  logic              wr_grant;
  logic              uflow_pop;

  // An in-flight read already owns a FIFO slot, so it counts toward the level.
  assign level       = {1'b0, fifo_cnt} + (CW+1)'(rd_inflight);
  assign disp_active = (state == RUN) && !i_frame_start && !i_rst;
  assign uflow_pop   = i_pix_pop && fifo_empty && !i_rst;

  always_comb begin
    rd_grant = 1'b0;
    wr_grant = 1'b0;
    if (!i_rst) begin
      if (disp_active && (level < LW_LVL))        rd_grant = 1'b1;
      else if (i_wr_req)                          wr_grant = 1'b1;
      else if (disp_active && (level < FULL_LVL)) rd_grant = 1'b1;
    end
  end

  assign o_mem_en    = rd_grant | wr_grant;
  assign o_mem_we    = wr_grant;
  assign o_mem_addr  = wr_grant ? i_wr_addr : rd_addr;
  assign o_mem_wdata = wr_grant ? i_wr_data : '0;
  assign o_wr_ack    = wr_grant;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state       <= WAIT_FRAME;
      rd_addr     <= '0;
      rd_inflight <= 1'b0;
      o_underflow <= 1'b0;
    end else begin
      if (i_frame_start) state <= RUN;
      rd_inflight <= rd_grant;
      if (i_frame_start)
        rd_addr <= '0;
      else if (rd_grant)
        rd_addr <= (rd_addr == LAST_ADR) ? '0 : rd_addr + ADDR_W'(1);
      if (i_frame_start)
        o_underflow <= 1'b0;
      else if (uflow_pop)
        o_underflow <= 1'b1;
    end
  end

  // Data returning during a frame start belongs to the old frame and is dropped.
  vga_fb_fifo #(.DATA_W(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .flush    (i_frame_start),
    .push_vld (rd_inflight && !i_frame_start),
    .push_dat (i_mem_rdata),
    .pop_vld  (i_pix_pop && !fifo_empty),
    .head_dat (fifo_head),
    .empty    (fifo_empty),
    .count    (fifo_cnt)
  );

  assign o_pix_data = fifo_empty ? '0 : fifo_head;

`ifdef VGA_FB_ARB_UFLOW_CNT_EN
  logic [15:0] uflow_cnt;
  always_ff @(posedge i_clk) begin
    if (i_rst)
      uflow_cnt <= '0;
    else if (uflow_pop && (uflow_cnt != 16'hFFFF))
      uflow_cnt <= uflow_cnt + 16'd1;
  end
  assign o_uflow_cnt = uflow_cnt;
`else
  assign o_uflow_cnt = '0;
`endif
endmodule
